nibble_serial_adder_8bit: RTL and testbench

NIBBLE_SERIAL_ADDER_8BIT -- requirements
Module: nibble_serial_adder_8bit

---
 rtl/nibble_adder_pkg.sv | 27 ++
 rtl/ripple_carry_adder.sv | 34 +++
 rtl/nibble_serial_adder_8bit.sv | 174 +++++++++++++++++
 tb/tb_nibble_serial_adder_8bit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_adder_pkg
// Shared definitions for the nibble-serial 8-bit adder:
//   - DATA_W / SLICE_W : operand width and width of the time-shared adder slice
//   - state_t          : 2-bit FSM encoding (IDLE=0, LO=1, HI=2, DONE=3)
//   - signed_ovf()     : two's-complement overflow rule from the sign bits
// -----------------------------------------------------------------------------
package nibble_adder_pkg;

  localparam int DATA_W  = 8;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Overflow happens when both operands share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
// Purely combinational 4-bit ripple-carry adder.
// Ports:
//   a, b  : input  [3:0] addends
//   cin   : input        carry-in
//   s     : output [3:0] sum
//   cout  : output       carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_carry_adder
  import nibble_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] carry_s;

  assign carry_s[0] = cin;

  genvar i;
  generate
    for (i = 0; i < SLICE_W; i++) begin : g_fa
      assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry_s[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_8bit.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_8bit
// Adds two 8-bit operands plus carry-in using one 4-bit ripple-carry adder,
// low nibble first, then high nibble. One transaction every 4 cycles:
// accept (IDLE) -> LO -> HI -> DONE (result held until consumed).
// Ports:
//   clk        : input        clock, rising edge
//   rst        : input        synchronous active-high reset
//   in_valid   : input        operand set offered
//   in_ready   : output       block can accept operands (IDLE only)
//   a, b       : input  [7:0] operands
//   cin        : input        carry-in
//   out_valid  : output       result held on s/cout/ovf (DONE only)
//   out_ready  : input        consumer accepts result
//   s          : output [7:0] (a+b+cin) mod 256
//   cout       : output       carry out of bit 7
//   ovf        : output       signed two's-complement overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder_8bit
  import nibble_adder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] s,
  output logic              cout,
  output logic              ovf
);

  state_t              state_r;
  state_t              state_nx_s;

  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic                cin_r;
  logic                nib_c_r;

  logic [DATA_W-1:0]   s_r;
  logic                cout_r;
  logic                ovf_r;
  logic                in_ready_r;
  logic                out_valid_r;

  logic [SLICE_W-1:0]  add_a_s;
  logic [SLICE_W-1:0]  add_b_s;
  logic                add_cin_s;
  logic [SLICE_W-1:0]  add_s_s;
  logic                add_cout_s;

  // Next-state logic for the accept / low / high / hold sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nx_s = LO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LO:   state_nx_s = HI;
      HI:   state_nx_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Steer the shared adder to the low or high slice; idle value elsewhere.
  always_comb begin
    add_a_s   = {SLICE_W{1'b0}};
    add_b_s   = {SLICE_W{1'b0}};
    add_cin_s = 1'b0;
    case (state_r)
      LO: begin
        add_a_s   = a_r[SLICE_W-1:0];
        add_b_s   = b_r[SLICE_W-1:0];
        add_cin_s = cin_r;
      end
      HI: begin
        add_a_s   = a_r[DATA_W-1:SLICE_W];
        add_b_s   = b_r[DATA_W-1:SLICE_W];
        add_cin_s = nib_c_r;
      end
      default: begin
        add_a_s   = {SLICE_W{1'b0}};
        add_b_s   = {SLICE_W{1'b0}};
        add_cin_s = 1'b0;
      end
    endcase
  end

  ripple_carry_adder u_rca (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .s    (add_s_s),
    .cout (add_cout_s)
  );

  // State register plus handshake flags registered from the next state,
  // so in_ready/out_valid come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
    end
  end

  // Operand capture on accept; held for the rest of the transaction so
  // later changes on a/b/cin cannot disturb the in-flight sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {DATA_W{1'b0}};
      b_r   <= {DATA_W{1'b0}};
      cin_r <= 1'b0;
    end else if ((state_r == IDLE) && in_valid) begin
      a_r   <= a;
      b_r   <= b;
      cin_r <= cin;
    end
  end

  // Result assembly: low nibble and inter-nibble carry in LO, high nibble,
  // carry-out and overflow in HI. Nothing changes in DONE, which holds the
  // result stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r     <= {DATA_W{1'b0}};
      nib_c_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        LO: begin
          s_r[SLICE_W-1:0] <= add_s_s;
          nib_c_r          <= add_cout_s;
        end
        HI: begin
          s_r[DATA_W-1:SLICE_W] <= add_s_s;
          cout_r                <= add_cout_s;
          ovf_r                 <= signed_ovf(a_r[DATA_W-1], b_r[DATA_W-1],
                                              add_s_s[SLICE_W-1]);
        end
        default: begin
          s_r <= s_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_8bit.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder_8bit
// Directed cases followed by randomized traffic. Expected results are pushed
// into a queue on every accepted operand set; a monitor pops and compares each
// time a result is consumed, and also checks latency and hold stability.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_8bit;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_res    = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  exp_t       exp_q[$];
  logic       prev_ov = 1'b0;
  logic [9:0] held    = 10'd0;

  nibble_serial_adder_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, overflow from the signed range.
  function automatic exp_t ref_add(input logic [7:0] x, input logic [7:0] y,
                                   input logic c);
    exp_t        r;
    int unsigned u;
    int          sx;
    int          sy;
    int          ci;
    ci     = c ? 1 : 0;
    u      = 32'(x) + 32'(y) + 32'(ci);
    sx     = $signed(x);
    sy     = $signed(y);
    r.s    = u[7:0];
    r.cout = u[8];
    r.ovf  = ((sx + sy + ci) > 127) || ((sx + sy + ci) < -128);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (out_valid && prev_ov) begin
      chk("hold_stable", 32'({s, cout, ovf}), 32'(held));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    if (out_valid && !prev_ov) begin
      chk("latency", 32'(cyc - acc_cyc), 32'd3);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got s=%02h cout=%0b ovf=%0b, want none",
                 s, cout, ovf);
      end else begin
        e = exp_q.pop_front();
        n_res++;
        n_checks++;
        if ({s, cout, ovf} !== {e.s, e.cout, e.ovf}) begin
          n_fail++;
          $display("FAIL result#%0d: got s=%02h cout=%0b ovf=%0b, want s=%02h cout=%0b ovf=%0b",
                   n_res, s, cout, ovf, e.s, e.cout, e.ovf);
        end
      end
    end
    if (rst) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(ref_add(a, b, cin));
      acc_cyc = cyc;
      n_acc++;
    end
    prev_ov = out_valid;
    held    = {s, cout, ovf};
  end

  // Offer one operand set while idle; optionally scramble a/b right after accept.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic scramble);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (scramble) begin
      a = 8'hAA;
      b = 8'hAA;
    end
  endtask

  task automatic wait_idle(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    if (!seen) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out_valid(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) chk("wait_out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int start;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, first cycle after release.
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);

    // Directed arithmetic cases.
    send(8'h3C, 8'h45, 1'b0, 1'b0);
    wait_idle(20);
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_idle(20);
    send(8'h0F, 8'h01, 1'b1, 1'b1);
    wait_idle(20);

    // Stall in DONE for 5 cycles, then release.
    out_ready = 1'b0;
    send(8'h80, 8'h80, 1'b1, 1'b0);
    wait_out_valid(10);
    repeat (5) @(negedge clk);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_value", 32'({s, cout, ovf}), 32'({8'h01, 1'b1, 1'b1}));
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // Reset during HI aborts the transaction.
    send(8'h7F, 8'h7F, 1'b1, 1'b0);   // now in LO
    @(posedge clk);                   // now in HI
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_stale", 32'(out_valid), 32'd0);
    end

    // Reset together with in_valid must not accept.
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'h11;
    b        = 8'h22;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_inval_no_accept", 32'({out_valid, in_ready}), 32'b01);
    end

    // Random traffic: random in_valid/out_ready and occasional resets.
    start = n_acc;
    for (int c = 0; c < 30000 && (n_acc - start) < 1000; c++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    if ((n_acc - start) < 1000) chk("random_accept_count", 32'(n_acc - start), 32'd1000);

    // Drain and confirm nothing was lost.
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
